// File: rtl/truth_table_sequencer_pkg.sv
// truth_table_seq_pkg: shared state encoding and vector-count helper for the truth-table sequencer.
package truth_table_seq_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  function automatic int vec_count(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if: host-side request/result bundle; master = host, slave = sequencer.
interface truth_table_sequencer_if
  import truth_table_seq_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2
);
  localparam int V = vec_count(N_IN);
  logic                 start;
  logic [N_OUT*V-1:0]   exp_table;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [V-1:0]         fail_vec;
  logic [N_IN-1:0]      first_fail;
  logic [N_OUT*V-1:0]   captured;
  modport master (output start, exp_table, input busy, done, pass, fail_vec, first_fail, captured);
  modport slave  (input start, exp_table, output busy, done, pass, fail_vec, first_fail, captured);
endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// seq_settle_timer: loadable down-counter holding each vector for SETTLE cycles; zero flags expiry.
module seq_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = $clog2(SETTLE + 1);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= W'(SETTLE - 1);
    else if (dec && !zero) cnt <= cnt - W'(1);
  end
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: clocked exhaustive sweep of a logic unit against an expected truth table.
// Define SEQ_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module truth_table_sequencer
  import truth_table_seq_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sequencer_if.slave host,
  output logic [N_IN-1:0]      dut_in,
  input  logic [N_OUT-1:0]     dut_out
);
  localparam int V = vec_count(N_IN);
  state_t               state, state_nx;
  logic [N_IN:0]        idx;
  logic [N_OUT*V-1:0]   exp_q;
  logic [N_OUT*V-1:0]   captured;
  logic [V-1:0]         fail_vec;
  logic [N_IN-1:0]      first_fail;
  logic                 pass;
  logic                 tmr_load, tmr_zero, mismatch, last, stop;
  logic [N_IN-1:0]      i_lo;
  assign i_lo     = idx[N_IN-1:0];
  assign mismatch = dut_out != exp_q[int'(i_lo)*N_OUT +: N_OUT];
  assign last     = idx == (N_IN+1)'(V - 1);
`ifdef SEQ_STOP_ON_FAIL_EN
  assign stop = last || mismatch;
`else
  assign stop = last;
`endif
  assign host.busy       = state != IDLE;
  assign host.done       = state == DONE;
  assign host.pass       = pass;
  assign host.fail_vec   = fail_vec;
  assign host.first_fail = first_fail;
  assign host.captured   = captured;
  seq_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .dec  (state == WAIT),
    .zero (tmr_zero)
  );
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    case (state)
      IDLE: begin
        state_nx = host.start ? WAIT : IDLE;
        tmr_load = host.start;
      end
      WAIT:   state_nx = tmr_zero ? SAMPLE : WAIT;
      SAMPLE: begin
        state_nx = stop ? DONE : WAIT;
        tmr_load = !stop;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // pass is resolved on the edge into DONE so it already reflects the final sample while done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      exp_q      <= '0;
      captured   <= '0;
      fail_vec   <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
      dut_in     <= '0;
    end else if (state == IDLE && host.start) begin
      idx        <= '0;
      exp_q      <= host.exp_table;
      captured   <= '0;
      fail_vec   <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
      dut_in     <= '0;
    end else if (state == SAMPLE) begin
      captured[int'(i_lo)*N_OUT +: N_OUT] <= dut_out;
      if (mismatch) fail_vec[i_lo] <= 1'b1;
      if (mismatch && !(|fail_vec)) first_fail <= i_lo;
      if (stop) pass <= !(|fail_vec || mismatch);
      else begin
        idx    <= idx + (N_IN+1)'(1);
        dut_in <= i_lo + N_IN'(1);
      end
    end
  end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: scoreboard bench; expected sweep results queued at start, checked at done.
module tb_truth_table_sequencer;
  typedef struct {
    int         lat;
    logic       pass;
    logic [3:0] fv;
    logic [1:0] ff;
    logic [7:0] cap;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  truth_table_sequencer_if #(.N_IN(2), .N_OUT(2)) h0 ();
  truth_table_sequencer_if #(.N_IN(1), .N_OUT(1)) h1 ();
  logic [1:0] dut_in0, dut_out0;
  logic [0:0] dut_in1, dut_out1;
  function automatic logic [1:0] unit2(input logic [1:0] v);
    return {~v[1] & v[0], ~v[1] | ~v[0]};
  endfunction
  assign dut_out0 = unit2(dut_in0);
  assign dut_out1 = ~dut_in1;
  truth_table_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .host(h0), .dut_in(dut_in0), .dut_out(dut_out0)
  );
  truth_table_sequencer #(.N_IN(1), .N_OUT(1), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .host(h1), .dut_in(dut_in1), .dut_out(dut_out1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model0(input logic [7:0] tbl);
    exp_t e;
    logic [1:0] o;
    int n;
    e.cap = '0; e.fv = '0; e.ff = '0; n = 0;
    for (int i = 0; i < 4; i++) begin
      o = unit2(2'(i));
      e.cap[i*2 +: 2] = o;
      n++;
      if (o != tbl[i*2 +: 2]) begin
        if (e.fv == 0) e.ff = 2'(i);
        e.fv[i] = 1'b1;
`ifdef SEQ_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    e.pass = e.fv == 0;
    e.lat = n * 2 + 1;
    return e;
  endfunction
  task automatic sweep0(input logic [7:0] tbl, input bit disturb);
    exp_t e;
    int cyc;
    bit seen;
    sb.push_back(model0(tbl));
    @(negedge clk);
    h0.exp_table = tbl;
    h0.start = 1'b1;
    @(negedge clk);
    h0.start = 1'b0;
    seen = 1'b0;
    for (cyc = 1; cyc < 100; cyc++) begin
      if (h0.done) begin
        seen = 1'b1;
        break;
      end
      check("dut_in_seq", 32'(dut_in0), 32'((cyc - 1) / 2));
      check("busy_sweep", 32'(h0.busy), 1);
      h0.start = disturb && (cyc == 3);
      if (disturb && cyc == 3) h0.exp_table = ~tbl;
      @(negedge clk);
    end
    h0.start = 1'b0;
    check("done_seen", 32'(seen), 1);
    e = sb.pop_front();
    check("latency", cyc, e.lat);
    check("pass", 32'(h0.pass), 32'(e.pass));
    check("fail_vec", 32'(h0.fail_vec), 32'(e.fv));
    check("first_fail", 32'(h0.first_fail), 32'(e.ff));
    check("captured", 32'(h0.captured), 32'(e.cap));
    check("busy_at_done", 32'(h0.busy), 1);
    @(negedge clk);
    check("done_pulse", 32'(h0.done), 0);
    check("busy_after", 32'(h0.busy), 0);
    check("pass_hold", 32'(h0.pass), 32'(e.pass));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    exp_t e;
    int cyc;
    bit seen;
    h0.start = 1'b0; h0.exp_table = '0;
    h1.start = 1'b0; h1.exp_table = '0;
    repeat (3) @(negedge clk);
    check("rst_dut_in", 32'(dut_in0), 0);
    check("rst_busy", 32'(h0.busy), 0);
    check("rst_done", 32'(h0.done), 0);
    check("rst_pass", 32'(h0.pass), 0);
    check("rst_fail_vec", 32'(h0.fail_vec), 0);
    check("rst_first_fail", 32'(h0.first_fail), 0);
    check("rst_captured", 32'(h0.captured), 0);
    rst_n = 1'b1;
    sweep0(8'h1D, 1'b0);
    sweep0(8'h1C, 1'b0);
    sweep0(8'h15, 1'b0);
    sweep0(8'h5D, 1'b0);
    sweep0(8'h1D, 1'b1);
    // abort mid-sweep with async reset, then confirm no done appears
    @(negedge clk);
    h0.exp_table = 8'h1C;
    h0.start = 1'b1;
    @(negedge clk);
    h0.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(h0.busy), 0);
    check("abort_dut_in", 32'(dut_in0), 0);
    check("abort_captured", 32'(h0.captured), 0);
    check("abort_fail_vec", 32'(h0.fail_vec), 0);
    check("abort_pass", 32'(h0.pass), 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (h0.done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 0);
    sweep0(8'h1D, 1'b0);
    // SETTLE=3 single-input inverter
    sb.push_back('{lat: 9, pass: 1'b1, fv: 4'h0, ff: 2'd0, cap: 8'h01});
    @(negedge clk);
    h1.exp_table = 2'b01;
    h1.start = 1'b1;
    @(negedge clk);
    h1.start = 1'b0;
    seen = 1'b0;
    for (cyc = 1; cyc < 100; cyc++) begin
      if (h1.done) begin
        seen = 1'b1;
        break;
      end
      check("inv_dut_in", 32'(dut_in1), 32'((cyc - 1) / 4));
      @(negedge clk);
    end
    check("inv_done_seen", 32'(seen), 1);
    e = sb.pop_front();
    check("inv_latency", cyc, e.lat);
    check("inv_pass", 32'(h1.pass), 32'(e.pass));
    check("inv_fail_vec", 32'(h1.fail_vec), 32'(e.fv));
    check("inv_captured", 32'(h1.captured), 32'(e.cap));
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Controller that exhaustively exercises a small combinational logic unit (N_IN inputs, N_OUT outputs, such as the two-input gate functions in the guide exercises). On `start` it drives every input combination in ascending binary order, waits a programmable settle time, samples the unit's outputs, and compares them against a caller-supplied expected truth table. It sits between a stimulus/host register and the logic unit, replacing hand-written `#1` stimulus sequences with a clocked, self-checking sweep.

## Interface
- `N_IN`, default 2: number of logic-unit inputs; vector count V = 2^N_IN; legal range 1..6.
- `N_OUT`, default 2: number of logic-unit outputs.
- `SETTLE`, default 1: cycles each vector is held before sampling; must be at least 1.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a sweep; ignored while `busy`.
- `exp_table` in N_OUT*V: expected outputs; entry i = `exp_table[i*N_OUT +: N_OUT]`; sampled only on an accepted `start`.
- `dut_in` out N_IN: registered input vector to the logic unit; `dut_in[N_IN-1]` is the first operand (x).
- `dut_out` in N_OUT: logic-unit outputs; must be stable after SETTLE cycles.
- `busy` out 1: high from the cycle after start acceptance until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse at sweep end.
- `pass` out 1: valid from `done` until the next accepted `start`; 1 only if every sampled vector matched.
- `fail_vec` out V: bit i set if vector i mismatched.
- `first_fail` out N_IN: index of the lowest mismatching vector; 0 if none.
- `captured` out N_OUT*V: observed outputs, same packing as `exp_table`.

## Operation
- Reset values: all outputs 0, state IDLE, and the internal exp copy 0.
- States and transitions:
  - IDLE: on `start`, latch `exp_table`, clear `fail_vec`, `captured`, `first_fail` and `pass`, set idx=0 and `dut_in`=0, load the settle counter with SETTLE-1, then go to WAIT.
  - WAIT: decrement the settle counter; at 0, go to SAMPLE.
  - SAMPLE: write `dut_out` into `captured` entry idx. If `dut_out` != exp entry idx, set `fail_vec[idx]`; if it is the first mismatch, set `first_fail`=idx. If idx = V-1, go to DONE. Otherwise increment idx, set `dut_in`=idx+1, reload the counter and go to WAIT.
  - DONE: assert `done` and set `pass` = ~|`fail_vec` (including the mismatch recorded on the final sample), then go to IDLE.
- Changing `exp_table` during a sweep has no effect.
- `start` in DONE or any busy state is ignored. It is not queued.
- Asserting `rst_n` low mid-sweep aborts immediately to reset values. No `done` is produced.
- idx is N_IN+1 bits wide internally so the V-1 comparison does not wrap.

## Timing
- `dut_in` changes only on the WAIT entry edge. It is held exactly SETTLE cycles in WAIT, plus the SAMPLE cycle.
- Cost per vector is SETTLE+1 cycles. From the start-accept edge to the `done` cycle is V*(SETTLE+1)+1 cycles.
- `captured`, `fail_vec` and `first_fail` update on the SAMPLE edge. They are final when `done` is high.
- `pass` updates on the DONE edge.

## Configuration
- `SEQ_STOP_ON_FAIL_EN` defined: a SAMPLE with a mismatch goes directly to DONE. `captured` entries above the failing index remain 0, and `fail_vec` has exactly one bit set.
- Macro undefined: all V vectors are always swept, regardless of mismatches.

## Structure
- Package `truth_table_seq_pkg` holds the state enum (IDLE, WAIT, SAMPLE, DONE) and the function `vec_count(n)` = 2^n.
- Sub-module `seq_settle_timer` is a loadable down-counter with a `zero` flag, width $clog2(SETTLE+1).

## Test plan
- Defaults, logic unit a=~x&y, b=~x|~y (out[1]=a, out[0]=b), `exp_table`=8'h1D, pulse `start`:
  - `dut_in` sequence 0,1,2,3, each held 2 cycles.
  - `done` 9 cycles after start.
  - `pass`=1, `fail_vec`=0, `captured`=8'h1D.
- Same sweep, `exp_table`=8'h1C (entry 0 wrong): `pass`=0, `fail_vec`=4'b0001, `first_fail`=0.
- `SEQ_STOP_ON_FAIL_EN` with `exp_table`=8'h15 (entry 1 wrong):
  - `done` after 5 cycles.
  - `fail_vec`=4'b0010, `first_fail`=1, `captured`=8'h0D.
- `start` pulsed again mid-sweep, and `exp_table` changed mid-sweep: results identical to the undisturbed 8'h1D run.
- `rst_n` low at cycle 4 of a sweep: all outputs 0 immediately, no `done`. A new `start` runs a clean sweep.
- SETTLE=3, N_IN=1, N_OUT=1, inverter unit, `exp_table`=2'b01: `done` 9 cycles after start, `pass`=1.
